// File: rtl/pipe_pkg.sv
// Shared definitions for the LEGv8 pipeline: zero register number,
// forwarding-select encoding, default control-bundle width and a
// register-match helper used by the bypass and write-through logic.
package pipe_pkg;

    localparam logic [4:0] XZR        = 5'd31;
    localparam int         CTRL_W_DEF = 16;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    // A writing stage matches a source when it writes that register and the
    // register is not XZR (XZR always reads as zero, never bypassed).
    function automatic logic reg_match(input logic       wr,
                                       input logic [4:0] rd,
                                       input logic [4:0] src);
        return wr && (rd == src) && (src != XZR);
    endfunction

endpackage

// File: rtl/fwd_sel_unit.sv
// Forwarding selector for one ALU operand. EX/MEM has priority over MEM/WB
// because it carries the younger result.
module fwd_sel_unit
    import pipe_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       exmem_reg_write_i,
    input  logic [4:0] exmem_rd_i,
    input  logic       memwb_reg_write_i,
    input  logic [4:0] memwb_rd_i,
    output fwd_sel_e   sel_o
);

    // Pick the youngest stage producing the source register.
    always_comb begin
        sel_o = FWD_REG;
        if (reg_match(exmem_reg_write_i, exmem_rd_i, src_i)) begin
            sel_o = FWD_EXMEM;
        end else if (reg_match(memwb_reg_write_i, memwb_rd_i, src_i)) begin
            sel_o = FWD_MEMWB;
        end else begin
            sel_o = FWD_REG;
        end
    end

endmodule

// File: rtl/mux2_1_64.sv
// 64-bit 2:1 multiplexer: sel_i=0 -> a_i, sel_i=1 -> b_i.
module mux2_1_64 (
    input  logic        sel_i,
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic [63:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register of the 5-stage LEGv8 core. Latches decoded
// operands/control, detects load-use hazards and drives forwarded ALU
// operands. Optional perf counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              hold,
    input  logic              id_valid,
    input  logic [63:0]       id_rd1,
    input  logic [63:0]       id_rd2,
    input  logic [63:0]       id_imm,
    input  logic [4:0]        id_rn,
    input  logic [4:0]        id_rm,
    input  logic [4:0]        id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              exmem_reg_write,
    input  logic [4:0]        exmem_rd,
    input  logic [63:0]       exmem_result,
    input  logic              memwb_reg_write,
    input  logic [4:0]        memwb_rd,
    input  logic [63:0]       memwb_result,
    output logic              load_use_stall,
    output logic              ex_valid,
    output logic [63:0]       ex_op_a,
    output logic [63:0]       ex_op_b,
    output logic [63:0]       ex_imm,
    output logic [4:0]        ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       hold_cnt
);

    logic              valid_q, valid_d;
    logic [63:0]       rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [4:0]        rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
    logic              reg_write_q, reg_write_d, mem_read_q, mem_read_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    fwd_sel_e          sel_a_s, sel_b_s;
    logic [63:0]       mid_a_s, mid_b_s;

    // Load-use hazard: the load in EX cannot bypass to the consumer in ID.
    always_comb begin
        load_use_stall = id_valid && valid_q && mem_read_q && (rd_q != XZR) &&
                         ((rd_q == id_rn) || (rd_q == id_rm));
    end

    // Next-state selection: reset > flush > hold > load-use bubble > load.
    always_comb begin
        valid_d     = valid_q;
        rd1_d       = rd1_q;
        rd2_d       = rd2_q;
        imm_d       = imm_q;
        rn_d        = rn_q;
        rm_d        = rm_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        ctrl_d      = ctrl_q;
        if (reset || flush || (!hold && load_use_stall)) begin
            valid_d     = 1'b0;
            rd1_d       = 64'd0;
            rd2_d       = 64'd0;
            imm_d       = 64'd0;
            rn_d        = 5'd0;
            rm_d        = 5'd0;
            rd_d        = 5'd0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            ctrl_d      = '0;
        end else if (hold) begin
            // Frozen, but keep the value retiring from MEM/WB during the freeze.
            if (reg_match(memwb_reg_write, memwb_rd, rn_q)) begin
                rd1_d = memwb_result;
            end else begin
                rd1_d = rd1_q;
            end
            if (reg_match(memwb_reg_write, memwb_rd, rm_q)) begin
                rd2_d = memwb_result;
            end else begin
                rd2_d = rd2_q;
            end
        end else begin
            valid_d     = id_valid;
            imm_d       = id_imm;
            rn_d        = id_rn;
            rm_d        = id_rm;
            rd_d        = id_rd;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
            ctrl_d      = id_ctrl;
            // Register-file write-through for a same-cycle MEM/WB write.
            rd1_d = reg_match(memwb_reg_write, memwb_rd, id_rn) ? memwb_result : id_rd1;
            rd2_d = reg_match(memwb_reg_write, memwb_rd, id_rm) ? memwb_result : id_rd2;
        end
    end

    // Pipeline register state update.
    always_ff @(posedge clk) begin
        valid_q     <= valid_d;
        rd1_q       <= rd1_d;
        rd2_q       <= rd2_d;
        imm_q       <= imm_d;
        rn_q        <= rn_d;
        rm_q        <= rm_d;
        rd_q        <= rd_d;
        reg_write_q <= reg_write_d;
        mem_read_q  <= mem_read_d;
        ctrl_q      <= ctrl_d;
    end

    fwd_sel_unit u_fwd_a (
        .src_i(rn_q), .exmem_reg_write_i(exmem_reg_write), .exmem_rd_i(exmem_rd),
        .memwb_reg_write_i(memwb_reg_write), .memwb_rd_i(memwb_rd), .sel_o(sel_a_s)
    );
    fwd_sel_unit u_fwd_b (
        .src_i(rm_q), .exmem_reg_write_i(exmem_reg_write), .exmem_rd_i(exmem_rd),
        .memwb_reg_write_i(memwb_reg_write), .memwb_rd_i(memwb_rd), .sel_o(sel_b_s)
    );

    mux2_1_64 u_mux_a_wb (.sel_i(sel_a_s == FWD_MEMWB), .a_i(rd1_q),   .b_i(memwb_result), .y_o(mid_a_s));
    mux2_1_64 u_mux_a_ex (.sel_i(sel_a_s == FWD_EXMEM), .a_i(mid_a_s), .b_i(exmem_result), .y_o(ex_op_a));
    mux2_1_64 u_mux_b_wb (.sel_i(sel_b_s == FWD_MEMWB), .a_i(rd2_q),   .b_i(memwb_result), .y_o(mid_b_s));
    mux2_1_64 u_mux_b_ex (.sel_i(sel_b_s == FWD_EXMEM), .a_i(mid_b_s), .b_i(exmem_result), .y_o(ex_op_b));

    assign fwd_a_sel    = sel_a_s;
    assign fwd_b_sel    = sel_b_s;
    assign ex_valid     = valid_q;
    assign ex_imm       = imm_q;
    assign ex_rd        = rd_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_ctrl      = ctrl_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d, hold_cnt_q, hold_cnt_d;
    logic        bubble_evt_s, hold_evt_s;

    // Saturating counts of loaded bubbles and hold cycles.
    always_comb begin
        bubble_evt_s = flush || (!hold && load_use_stall);
        hold_evt_s   = hold && !flush;
        if (reset) begin
            bubble_cnt_d = 32'd0;
            hold_cnt_d   = 32'd0;
        end else begin
            bubble_cnt_d = (bubble_evt_s && (bubble_cnt_q != 32'hFFFF_FFFF)) ? bubble_cnt_q + 32'd1 : bubble_cnt_q;
            hold_cnt_d   = (hold_evt_s && (hold_cnt_q != 32'hFFFF_FFFF)) ? hold_cnt_q + 32'd1 : hold_cnt_q;
        end
    end

    // Counter state update.
    always_ff @(posedge clk) begin
        bubble_cnt_q <= bubble_cnt_d;
        hold_cnt_q   <= hold_cnt_d;
    end

    assign bubble_cnt = bubble_cnt_q;
    assign hold_cnt   = hold_cnt_q;
`else
    assign bubble_cnt = 32'd0;
    assign hold_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg; counter expectations follow the
// ID_EX_PERF_CNT_EN build setting.
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        reset, flush, hold, id_valid;
    logic [63:0] id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rn, id_rm, id_rd;
    logic        id_reg_write, id_mem_read;
    logic [15:0] id_ctrl;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [63:0] exmem_result, memwb_result;
    logic        load_use_stall, ex_valid, ex_reg_write, ex_mem_read;
    logic [63:0] ex_op_a, ex_op_b, ex_imm;
    logic [4:0]  ex_rd;
    logic [15:0] ex_ctrl;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] bubble_cnt, hold_cnt;

    int vectors = 0;
    int miscompares = 0;

`ifdef ID_EX_PERF_CNT_EN
    localparam logic CNT_ON = 1'b1;
`else
    localparam logic CNT_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .reset(reset), .flush(flush), .hold(hold), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_rn(id_rn), .id_rm(id_rm),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_ctrl(id_ctrl),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_ctrl(ex_ctrl), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input logic [31:0] v);
        return CNT_ON ? v : 32'd0;
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; hold = 1'b0;
        id_valid = 1'b1; id_rd1 = 64'h5; id_rd2 = 64'h0; id_imm = 64'h0;
        id_rn = 5'd0; id_rm = 5'd0; id_rd = 5'd0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_ctrl = 16'h0;
        exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 64'h0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 64'h0;

        // 1: reset dominates a valid instruction
        tick();
        chk("rst_valid", ex_valid, 64'd0);
        chk("rst_op_a", ex_op_a, 64'd0);
        chk("rst_bcnt", bubble_cnt, 64'd0);
        chk("rst_hcnt", hold_cnt, 64'd0);
        reset = 1'b0;

        // 2: plain load, then EX/MEM and MEM/WB forwarding of Rn
        id_rn = 5'd3; id_rd1 = 64'hA; id_rm = 5'd4; id_rd2 = 64'h44; id_rd = 5'd5;
        id_imm = 64'h123; id_reg_write = 1'b1; id_ctrl = 16'h1234;
        tick();
        chk("ld_valid", ex_valid, 64'd1);
        chk("ld_op_a", ex_op_a, 64'hA);
        chk("ld_op_b", ex_op_b, 64'h44);
        chk("ld_imm", ex_imm, 64'h123);
        chk("ld_rd", ex_rd, 64'd5);
        chk("ld_ctrl", ex_ctrl, 64'h1234);
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 64'hBEEF;
        #1;
        chk("exmem_op_a", ex_op_a, 64'hBEEF);
        chk("exmem_sel_a", fwd_a_sel, 64'd2);
        memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 64'h1;
        #1;
        chk("prio_op_a", ex_op_a, 64'hBEEF);
        chk("prio_sel_a", fwd_a_sel, 64'd2);
        exmem_reg_write = 1'b0;
        #1;
        chk("memwb_op_a", ex_op_a, 64'h1);
        chk("memwb_sel_a", fwd_a_sel, 64'd1);
        chk("memwb_sel_b", fwd_b_sel, 64'd0);
        memwb_reg_write = 1'b0;

        // 3: load in EX, dependent Rm in ID -> stall and bubble
        id_rn = 5'd1; id_rm = 5'd6; id_rd = 5'd2; id_mem_read = 1'b1;
        tick();
        id_rn = 5'd8; id_rm = 5'd2; id_rd = 5'd9; id_mem_read = 1'b0;
        #1;
        chk("lu_stall", load_use_stall, 64'd1);
        tick();
        chk("lu_valid", ex_valid, 64'd0);
        chk("lu_rw", ex_reg_write, 64'd0);
        chk("lu_ctrl", ex_ctrl, 64'd0);
        chk("lu_bcnt", bubble_cnt, cnt(32'd1));
        chk("lu_stall_clr", load_use_stall, 64'd0);

        // load writing XZR never stalls
        id_rd = 5'd31; id_mem_read = 1'b1;
        tick();
        id_rn = 5'd31; id_mem_read = 1'b0;
        #1;
        chk("xzr_nostall", load_use_stall, 64'd0);

        // 4: XZR source never forwarded
        id_rd1 = 64'h31; id_rd = 5'd12;
        tick();
        exmem_reg_write = 1'b1; exmem_rd = 5'd31; exmem_result = 64'hDEAD;
        memwb_reg_write = 1'b1; memwb_rd = 5'd31; memwb_result = 64'hCAFE;
        #1;
        chk("xzr_sel_a", fwd_a_sel, 64'd0);
        chk("xzr_op_a", ex_op_a, 64'h31);
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

        // 5: hold with MEM/WB retiring latched Rm
        id_rn = 5'd0; id_rd1 = 64'h0; id_rm = 5'd7; id_rd2 = 64'h70; id_rd = 5'd10;
        tick();
        chk("pre_hold_op_b", ex_op_b, 64'h70);
        hold = 1'b1; id_rm = 5'd9; id_rd2 = 64'hFF; id_rd = 5'd11;
        memwb_reg_write = 1'b1; memwb_rd = 5'd7; memwb_result = 64'h77;
        tick();
        tick();
        hold = 1'b0; memwb_reg_write = 1'b0;
        #1;
        chk("hold_op_b", ex_op_b, 64'h77);
        chk("hold_sel_b", fwd_b_sel, 64'd0);
        chk("hold_rd", ex_rd, 64'd10);
        chk("hold_hcnt", hold_cnt, cnt(32'd2));

        // flush together with hold: bubble wins, hold not counted
        hold = 1'b1; flush = 1'b1;
        tick();
        hold = 1'b0; flush = 1'b0;
        chk("fh_valid", ex_valid, 64'd0);
        chk("fh_hcnt", hold_cnt, cnt(32'd2));
        chk("fh_bcnt", bubble_cnt, cnt(32'd2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
